// File: rtl/state_machine_cpu_pkg.sv
// state_machine_cpu_pkg: shared types and constants for the y = 3x + 8 sequencer
// Provides the controller state encoding, the ALU opcode set and the affine constants.
package state_machine_cpu_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SHL, ADDX, ADDC, DONE} state_t;
    typedef enum logic [1:0] {ALU_PASS, ALU_SHL1, ALU_ADD} alu_op_t;
    localparam int COEF = 3;
    localparam logic signed [31:0] OFFSET = 32'sd8;
endpackage

// File: rtl/state_machine_alu.sv
// state_machine_alu: combinational 32-bit ALU shared by every micro-operation
// Ports: a, b - signed operands; op - PASS/SHL1/ADD; r - signed result.
module state_machine_alu
    import state_machine_cpu_pkg::*;
(
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    input  alu_op_t            op,
    output logic signed [31:0] r
);
    always_comb r = op == ALU_SHL1 ? a << 1 : op == ALU_ADD ? a + b : a;
endmodule

// File: rtl/state_machine_cpu.sv
// state_machine_cpu: FSM-sequenced datapath computing y = 3x + 8, one micro-op per clock
// Ports: clk, rst_n (async, active-low); start + x_in launch a run from IDLE;
// y_out holds the last result; done pulses for one cycle when y_out updates.
module state_machine_cpu
    import state_machine_cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [15:0]  x_in,
    output logic signed [31:0]  y_out,
    output logic                done
);
    state_t            state, state_nx;
    alu_op_t           op;
    logic signed [31:0] x_reg, acc, alu_a, alu_b, alu_r;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = start ? LOAD : IDLE;
            LOAD:    state_nx = SHL;
            SHL:     state_nx = ADDX;
            ADDX:    state_nx = ADDC;
            ADDC:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // LOAD routes x_reg through the ALU; later steps work on acc, and only ADDC adds the offset.
    always_comb begin
        op    = state == LOAD ? ALU_PASS : state == SHL ? ALU_SHL1 : ALU_ADD;
        alu_a = state == LOAD ? x_reg : acc;
        alu_b = state == ADDC ? OFFSET : x_reg;
    end

    state_machine_alu u_alu (.a(alu_a), .b(alu_b), .op(op), .r(alu_r));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            x_reg <= '0;
            acc   <= '0;
            y_out <= '0;
            done  <= 1'b0;
        end else begin
            if (state == IDLE && start) x_reg <= {{16{x_in[15]}}, x_in};
            if (state inside {LOAD, SHL, ADDX, ADDC}) acc <= alu_r;
            if (state == DONE) y_out <= acc;
            done <= state == DONE;
        end
endmodule

// File: tb/tb_state_machine_cpu.sv
// tb_state_machine_cpu: table-driven, scoreboarded bench for state_machine_cpu
module tb_state_machine_cpu;
    import state_machine_cpu_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic signed [15:0] x_in = '0;
    logic signed [31:0] y_out;
    logic               done;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_q[$];

    typedef struct {
        logic signed [15:0] x;
        int                 y;
    } vec_t;
    vec_t vecs[6];

    state_machine_cpu dut (.clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_out(y_out), .done(done));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk)
        if (done === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious_done", 1, 0);
            else chk("y_out", y_out, exp_q.pop_front());
        end

    task automatic run_one(input logic signed [15:0] x, input int exp);
        logic signed [31:0] prev;
        int k;
        bit held;
        prev = y_out;
        held = 1;
        start = 1'b1;
        x_in = x;
        exp_q.push_back(exp);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                x_in = 16'sh5a5a;
            end
            if (!done && y_out !== prev) held = 0;
        end while (!done && k < 20);
        chk("latency", k, 6);
        chk("hold_prev", held, 1);
        @(negedge clk);
        chk("pulse_width", done, 0);
    endtask

    initial begin
        int dc, k, first, second;
        vecs[0] = '{16'sd10, 38};
        vecs[1] = '{-16'sd4, -4};
        vecs[2] = '{16'sd32767, 98309};
        vecs[3] = '{-16'sd32768, -98296};
        vecs[4] = '{16'sd0, 8};
        vecs[5] = '{16'sd123, 377};

        repeat (2) @(negedge clk);
        chk("rst_y", y_out, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        dc = 0;
        repeat (10) begin @(negedge clk); dc += int'(done); end
        chk("idle_no_done", dc, 0);

        foreach (vecs[i]) run_one(vecs[i].x, vecs[i].y);

        // start and a new x_in during SHL must not disturb the run in flight
        start = 1'b1; x_in = 16'sd100; exp_q.push_back(308);
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; x_in = 16'sd5;
        @(negedge clk); start = 1'b0;
        k = 3;
        while (!done && k < 20) begin @(negedge clk); k++; end
        chk("busy_latency", k, 6);
        dc = 0;
        repeat (8) begin @(negedge clk); dc += int'(done); end
        chk("busy_no_restart", dc, 0);

        // start held high relaunches on the IDLE cycle right after DONE
        start = 1'b1; x_in = 16'sd7;
        exp_q.push_back(29); exp_q.push_back(29);
        first = 0; second = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (done && first == 0) first = n;
            else if (done) second = n;
            if (n == 7) start = 1'b0;
        end
        chk("b2b_first", first, 6);
        chk("b2b_spacing", second - first, 6);

        // reset during ADDX discards the run
        start = 1'b1; x_in = 16'sd50; exp_q.push_back(158);
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_state", dut.state, ADDX);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_y", y_out, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_state", dut.state, IDLE);
        void'(exp_q.pop_back());
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_one(-16'sd100, -292);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
